// File: rtl/user_request_queue.sv
// Three-user request queue feeding a downstream round-robin arbiter.
// Each user owns a DEPTH-entry FIFO; a one-hot grant pops that user's head into
// a registered issue stage one cycle later.
// Optional feature: define USER_QUEUE_ERR_EN to add sticky error_flags_o
// (bit0 dropped push, bit1 grant to empty queue, bit2 multi-hot grant).
module user_request_queue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_valid_i,
    input  logic [1:0]        push_user_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [2:0]        granted_i,
    output logic [2:0]        user_requests_o,
    output logic [2:0]        full_o,
`ifdef USER_QUEUE_ERR_EN
    output logic [2:0]        error_flags_o,
`endif
    output logic              issue_valid_o,
    output logic [1:0]        issue_user_o,
    output logic [DATA_W-1:0] issue_data_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [DATA_W-1:0] mem_q    [3][DEPTH];
    logic [PtrW-1:0]   rd_ptr_q [3];
    logic [PtrW-1:0]   rd_ptr_d [3];
    logic [PtrW-1:0]   wr_ptr_q [3];
    logic [PtrW-1:0]   wr_ptr_d [3];
    logic [CntW-1:0]   count_q  [3];
    logic [CntW-1:0]   count_d  [3];

    logic              issue_valid_q, issue_valid_d;
    logic [1:0]        issue_user_q, issue_user_d;
    logic [DATA_W-1:0] issue_data_q, issue_data_d;

    logic              grant_onehot;
    logic [1:0]        gnt_idx;
    logic [2:0]        pop;
    logic              pop_any;
    logic [3:0]        full_pad;
    logic [3:0]        pop_pad;
    logic              push_ok;
    logic [2:0]        push;

    // Status decoded purely from registered counts (no push->request path).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            user_requests_o[i] = (count_q[i] != '0);
            full_o[i]          = (count_q[i] == CntFull);
        end
    end

    // Grant decode, push acceptance and per-queue pointer/count next state.
    always_comb begin
        grant_onehot = (granted_i != 3'b000) && ((granted_i & (granted_i - 3'd1)) == 3'b000);
        if (granted_i[1]) begin
            gnt_idx = 2'd1;
        end else if (granted_i[2]) begin
            gnt_idx = 2'd2;
        end else begin
            gnt_idx = 2'd0;
        end
        for (int i = 0; i < 3; i++) begin
            pop[i] = grant_onehot && granted_i[i] && (count_q[i] != '0);
        end
        pop_any = |pop;
        // Padded so that the illegal user 3 indexes a safe "full, no pop" slot.
        full_pad = {1'b1, full_o};
        pop_pad  = {1'b0, pop};
        push_ok  = push_valid_i && (push_user_i != 2'd3) &&
                   (!full_pad[push_user_i] || pop_pad[push_user_i]);
        for (int i = 0; i < 3; i++) begin
            push[i]     = push_ok && (push_user_i == 2'(i));
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PtrW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i] ? rd_ptr_q[i] + PtrW'(1) : rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CntW'(1);
            end else if (!push[i] && pop[i]) begin
                count_d[i] = count_q[i] - CntW'(1);
            end
        end
        issue_valid_d = pop_any;
        issue_user_d  = pop_any ? gnt_idx : issue_user_q;
        issue_data_d  = pop_any ? mem_q[gnt_idx][rd_ptr_q[gnt_idx]] : issue_data_q;
    end

    // Pointer, count and issue-stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_user_q  <= 2'd0;
            issue_data_q  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_user_q  <= issue_user_d;
            issue_data_q  <= issue_data_d;
        end
    end

    // Queue storage; never reset, only visible through a non-empty queue.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[push_user_i][wr_ptr_q[push_user_i]] <= push_data_i;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_user_o  = issue_user_q;
    assign issue_data_o  = issue_data_q;

`ifdef USER_QUEUE_ERR_EN
    logic [2:0] err_q, err_d;
    logic       grant_multi;

    // Sticky error flags, cleared only by reset.
    always_comb begin
        grant_multi = (granted_i & (granted_i - 3'd1)) != 3'b000;
        err_d       = err_q | {grant_multi, grant_onehot && !pop_any, push_valid_i && !push_ok};
    end

    // Error flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign error_flags_o = err_q;
`endif

endmodule

// File: tb/tb_user_request_queue.sv
// Self-checking bench for user_request_queue: directed vector table, directed
// corner sequences and randomized traffic against a queue-based reference model.
module tb_user_request_queue;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic [1:0]    push_user;
    logic [DW-1:0] push_data;
    logic [2:0]    granted;
    logic [2:0]    user_requests;
    logic [2:0]    full;
    logic          issue_valid;
    logic [1:0]    issue_user;
    logic [DW-1:0] issue_data;
`ifdef USER_QUEUE_ERR_EN
    logic [2:0]    error_flags;
`endif

    always #5 clk = ~clk;

    user_request_queue #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .push_valid_i    (push_valid),
        .push_user_i     (push_user),
        .push_data_i     (push_data),
        .granted_i       (granted),
        .user_requests_o (user_requests),
        .full_o          (full),
`ifdef USER_QUEUE_ERR_EN
        .error_flags_o   (error_flags),
`endif
        .issue_valid_o   (issue_valid),
        .issue_user_o    (issue_user),
        .issue_data_o    (issue_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one plain queue per user plus the issue stage.
    logic [DW-1:0] mq [3][$];
    logic          m_iv;
    logic [1:0]    m_iu;
    logic [DW-1:0] m_id;
    logic [2:0]    m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare every output to it.
    task automatic step(input logic pv, input logic [1:0] pu, input logic [DW-1:0] pd,
                        input logic [2:0] g, input logic r);
        int  gi;
        bit  onehot, pop, acc;
        logic [2:0] m_ur, m_fl;
        rst = r; push_valid = pv; push_user = pu; push_data = pd; granted = g;
        if (r) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_iv = 1'b0; m_iu = 2'd0; m_id = '0; m_err = 3'b000;
        end else begin
            onehot = ($countones(g) == 1);
            gi     = (g == 3'b010) ? 1 : (g == 3'b100) ? 2 : 0;
            pop    = onehot && (mq[gi].size() > 0);
            acc    = pv && (pu != 2'd3) &&
                     ((mq[pu].size() < DEPTH) || (pop && gi == int'(pu)));
            if (pv && !acc) m_err[0] = 1'b1;
            if (onehot && !pop) m_err[1] = 1'b1;
            if ($countones(g) > 1) m_err[2] = 1'b1;
            if (pop) begin
                m_id = mq[gi].pop_front();
                m_iu = 2'(gi);
            end
            m_iv = pop;
            if (acc) mq[pu].push_back(pd);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_ur[i] = (mq[i].size() != 0);
            m_fl[i] = (mq[i].size() == DEPTH);
        end
        chk("user_requests", 32'(user_requests), 32'(m_ur));
        chk("full", 32'(full), 32'(m_fl));
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        chk("issue_user", 32'(issue_user), 32'(m_iu));
        chk("issue_data", 32'(issue_data), 32'(m_id));
`ifdef USER_QUEUE_ERR_EN
        chk("error_flags", 32'(error_flags), 32'(m_err));
`endif
    endtask

    typedef struct {
        logic          pv;
        logic [1:0]    pu;
        logic [DW-1:0] pd;
        logic [2:0]    g;
        logic [2:0]    ur;
        logic [2:0]    fl;
        logic          iv;
        logic [1:0]    iu;
        logic [DW-1:0] id;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_user = 2'd0; push_data = '0; granted = 3'b000;
        m_iv = 1'b0; m_iu = 2'd0; m_id = '0; m_err = 3'b000;

        // Hand-derived expectations, outputs observed after each edge.
        tbl[0] = '{1'b1, 2'd1, 8'h5A, 3'b000, 3'b010, 3'b000, 1'b0, 2'd0, 8'h00};
        tbl[1] = '{1'b0, 2'd0, 8'h00, 3'b010, 3'b000, 3'b000, 1'b1, 2'd1, 8'h5A};
        tbl[2] = '{1'b0, 2'd0, 8'h00, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 8'h5A};
        tbl[3] = '{1'b0, 2'd0, 8'h00, 3'b001, 3'b000, 3'b000, 1'b0, 2'd1, 8'h5A};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 3'b011, 3'b000, 3'b000, 1'b0, 2'd1, 8'h5A};
        tbl[5] = '{1'b1, 2'd3, 8'h77, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 8'h5A};
        tbl[6] = '{1'b1, 2'd0, 8'h11, 3'b100, 3'b001, 3'b000, 1'b0, 2'd1, 8'h5A};
        tbl[7] = '{1'b1, 2'd2, 8'h22, 3'b001, 3'b100, 3'b000, 1'b1, 2'd0, 8'h11};
        tbl[8] = '{1'b0, 2'd0, 8'h00, 3'b110, 3'b100, 3'b000, 1'b0, 2'd0, 8'h11};
        tbl[9] = '{1'b0, 2'd0, 8'h00, 3'b100, 3'b000, 3'b000, 1'b1, 2'd2, 8'h22};

        // Reset state.
        step(1'b0, 2'd0, '0, 3'b000, 1'b1);
        step(1'b0, 2'd0, '0, 3'b000, 1'b1);
        chk("reset_ur", 32'(user_requests), 32'd0);
        chk("reset_iv_iu_id", {issue_valid, issue_user, issue_data}, 32'd0);

        // Directed vector table.
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].pv, tbl[k].pu, tbl[k].pd, tbl[k].g, 1'b0);
            chk($sformatf("tbl%0d_ur", k), 32'(user_requests), 32'(tbl[k].ur));
            chk($sformatf("tbl%0d_full", k), 32'(full), 32'(tbl[k].fl));
            chk($sformatf("tbl%0d_iv", k), 32'(issue_valid), 32'(tbl[k].iv));
            chk($sformatf("tbl%0d_iu", k), 32'(issue_user), 32'(tbl[k].iu));
            chk($sformatf("tbl%0d_id", k), 32'(issue_data), 32'(tbl[k].id));
        end
`ifdef USER_QUEUE_ERR_EN
        chk("tbl_err", 32'(error_flags), 32'd7);
`endif

        // Overfill user0: full after 4 pushes, 5th dropped, FIFO order on drain.
        step(1'b0, 2'd0, '0, 3'b000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'd0, 8'(8'hA0 + k), 3'b000, 1'b0);
            if (k == 3) chk("fill_full0", 32'(full[0]), 32'd1);
        end
`ifdef USER_QUEUE_ERR_EN
        chk("fill_drop_err", 32'(error_flags[0]), 32'd1);
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'd0, '0, 3'b001, 1'b0);
            chk("drain_data", 32'(issue_data), 32'(8'hA0 + k));
        end
        chk("drain_empty", 32'(user_requests), 32'd0);

        // Push into a full queue while it is being popped.
        for (int k = 0; k < 4; k++) step(1'b1, 2'd2, 8'(8'hC0 + k), 3'b000, 1'b0);
        step(1'b1, 2'd2, 8'hC4, 3'b100, 1'b0);
        chk("pushpop_full2", 32'(full[2]), 32'd1);
        chk("pushpop_head", 32'(issue_data), 32'hC0);
        for (int k = 1; k < 5; k++) step(1'b0, 2'd0, '0, 3'b100, 1'b0);
        chk("pushpop_last", 32'(issue_data), 32'hC4);
        chk("pushpop_lastv", 32'(issue_valid), 32'd1);

        // Reset mid-stream with a concurrent push and grant.
        for (int k = 0; k < 6; k++) step(1'b1, 2'(k % 3), 8'(8'h30 + k), 3'b000, 1'b0);
        step(1'b1, 2'd1, 8'hEE, 3'b001, 1'b1);
        chk("midrst_ur", 32'(user_requests), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_issue", {issue_valid, issue_user, issue_data}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd0, '0, 3'(1 << k), 1'b0);
            chk("midrst_noissue", 32'(issue_valid), 32'd0);
        end

        // Randomized traffic with occasional reset, exercising pointer wrap.
        for (int k = 0; k < 1500; k++) begin
            logic [2:0] g;
            int         r;
            r = int'($urandom_range(0, 9));
            if (r < 6) g = 3'(1 << $urandom_range(0, 2));
            else if (r == 6) g = 3'b000;
            else g = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 DW'($urandom), g, ($urandom_range(0, 299) == 0));
        end
        // Drain whatever remains.
        for (int k = 0; k < 3 * DEPTH + 3; k++) step(1'b0, 2'd0, '0, 3'(1 << (k % 3)), 1'b0);
        chk("final_empty", 32'(user_requests), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
